// File: rtl/pdp8_tt_fifo.sv
// ============================================================================
// Module   : pdp8_tt_fifo
// Purpose  : Buffered PDP-8 console IOT device with RX/TX byte FIFOs.
//            Define TT_KIE_EN to add the KIE/TSK interrupt-enable codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdp8_tt_fifo #(
    parameter logic [5:0] TTI_DEV    = 6'o03,
    parameter logic [5:0] TTO_DEV    = 6'o04,
    parameter int         DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        iot,
    input  logic [3:0]  state,
    input  logic [11:0] mb,
    input  logic [5:0]  io_select,
    input  logic [11:0] io_data_in,
    output logic [11:0] io_data_out,
    output logic        io_selected,
    output logic        io_data_avail,
    output logic        io_skip,
    output logic        io_interrupt,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_overrun
);

    localparam int                  c_ENTRIES = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = 1;
    localparam logic [3:0]          c_F1      = 4'b0001;

    logic w_act, w_tti, w_tto, w_kie, w_tsk, w_ie;
    logic w_unused;

    assign w_act    = iot && (state == c_F1);
    assign w_tti    = w_act && (io_select == TTI_DEV);
    assign w_tto    = w_act && (io_select == TTO_DEV);
    assign w_unused = ^mb[11:3];

`ifdef TT_KIE_EN
    logic ie_q;
    assign w_kie = w_tti && (mb[2:0] == 3'b101);
    assign w_tsk = w_tto && (mb[2:0] == 3'b101);
    assign w_ie  = ie_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   ie_q <= 1'b1;
        else if (w_kie) ie_q <= io_data_in[0];
    end
`else
    assign w_kie = 1'b0;
    assign w_tsk = 1'b0;
    assign w_ie  = 1'b1;
`endif

    // ---------------- RX FIFO (UART -> CPU) ----------------
    logic [7:0]            rx_mem_q [c_ENTRIES];
    logic [DEPTH_LOG2-1:0] rx_wr_q, rx_rd_q;
    logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
    logic                  w_rx_full, w_rx_flag, w_rx_push, w_rx_pop;

    assign w_rx_full = (rx_cnt_q == c_DEPTH);
    assign w_rx_flag = (rx_cnt_q != '0);
    assign rx_ready  = !w_rx_full;
    assign w_rx_push = rx_valid && !w_rx_full;
    assign w_rx_pop  = w_tti && mb[1] && w_rx_flag;

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        case ({w_rx_push, w_rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + c_CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - c_CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (w_rx_push) rx_wr_q <= rx_wr_q + c_PTR_ONE;
            if (w_rx_pop)  rx_rd_q <= rx_rd_q + c_PTR_ONE;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) rx_mem_q[rx_wr_q] <= rx_data;
    end

    // ---------------- TX FIFO (CPU -> UART) ----------------
    logic [7:0]            tx_mem_q [c_ENTRIES];
    logic [DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q;
    logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
    logic                  tx_flag_q, tx_flag_d, tx_ovr_q;
    logic                  w_tx_full, w_tpc, w_tx_push, w_tx_pop;

    assign w_tx_full = (tx_cnt_q == c_DEPTH);
    assign tx_valid  = (tx_cnt_q != '0);
    assign tx_data   = tx_mem_q[tx_rd_q];
    assign w_tx_pop  = tx_valid && tx_ready;
    assign w_tpc     = w_tto && mb[2] && !w_tsk;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_tx_push = w_tpc && (!w_tx_full || w_tx_pop);

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({w_tx_push, w_tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + c_CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - c_CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        tx_flag_d = tx_flag_q;
        if (w_tx_pop) tx_flag_d = 1'b1;
        // TCF overrides a same-edge pop; TLS recomputes from post-push occupancy.
        if (w_tto && mb[1]) tx_flag_d = mb[2] ? (tx_cnt_d != c_DEPTH) : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            tx_flag_q <= 1'b1;
            tx_ovr_q  <= 1'b0;
        end else begin
            if (w_tx_push) tx_wr_q <= tx_wr_q + c_PTR_ONE;
            if (w_tx_pop)  tx_rd_q <= tx_rd_q + c_PTR_ONE;
            if (w_tpc && !w_tx_push) tx_ovr_q <= 1'b1;
            tx_cnt_q  <= tx_cnt_d;
            tx_flag_q <= tx_flag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) tx_mem_q[tx_wr_q] <= io_data_in[7:0];
    end

    assign tx_overrun    = tx_ovr_q;
    assign io_data_avail = 1'b1;
    assign io_interrupt  = w_ie && (w_rx_flag || tx_flag_q);

    // ---------------- IOT response ----------------
    always_comb begin
        io_skip     = 1'b0;
        io_selected = 1'b0;
        io_data_out = io_data_in;
        if (w_tti) begin
            io_selected = 1'b1;
            if (!w_kie) begin
                io_skip     = mb[0] && w_rx_flag;
                io_data_out = mb[2] ? {4'b0000, rx_mem_q[rx_rd_q]} : 12'o0000;
            end
        end else if (w_tto) begin
            io_selected = 1'b1;
            io_skip     = w_tsk ? (w_rx_flag || tx_flag_q) : (mb[0] && tx_flag_q);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pdp8_tt_fifo.sv
// ============================================================================
// Module   : tb_pdp8_tt_fifo
// Purpose  : Self-checking bench for pdp8_tt_fifo (decode table + FIFO scoreboards).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdp8_tt_fifo;

    localparam logic [5:0] c_TTI   = 6'o03;
    localparam logic [5:0] c_TTO   = 6'o04;
    localparam int         c_DEPTH = 8;
    localparam logic [3:0] c_F1    = 4'b0001;

    logic        clk = 1'b0, reset_n = 1'b0, iot = 1'b0;
    logic [3:0]  state = 4'd0;
    logic [11:0] mb = '0, io_data_in = '0;
    logic [5:0]  io_select = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0, tx_ready = 1'b0;
    logic [11:0] io_data_out;
    logic        io_selected, io_data_avail, io_skip, io_interrupt;
    logic        rx_ready, tx_valid, tx_overrun;
    logic [7:0]  tx_data;

    pdp8_tt_fifo #(.TTI_DEV(c_TTI), .TTO_DEV(c_TTO), .DEPTH_LOG2(3)) dut (
        .clk(clk), .reset_n(reset_n), .iot(iot), .state(state), .mb(mb),
        .io_select(io_select), .io_data_in(io_data_in), .io_data_out(io_data_out),
        .io_selected(io_selected), .io_data_avail(io_data_avail), .io_skip(io_skip),
        .io_interrupt(io_interrupt), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_overrun(tx_overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [11:0] r_dout;
    logic        r_skip, r_sel, r_irq;

    typedef struct {
        logic [5:0]  dev;
        logic [2:0]  p;
        logic [3:0]  st;
        logic [11:0] ac;
        logic        e_sel;
        logic        e_skip;
        logic [11:0] e_dout;
        logic        e_irq;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART side: every byte leaving the TX FIFO must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) check("tx_unexpected_byte", {24'b0, tx_data}, 32'hFFFF_FFFF);
            else                  check("tx_byte", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
        end
    end

    task automatic drive_iot(input logic [5:0] dev, input logic [2:0] p,
                             input logic [11:0] ac, input logic [3:0] st);
        iot = 1'b1; state = st; io_select = dev; mb = {3'o6, dev, p}; io_data_in = ac;
    endtask

    task automatic do_iot(input logic [5:0] dev, input logic [2:0] p,
                          input logic [11:0] ac, input logic [3:0] st);
        @(posedge clk); #1;
        drive_iot(dev, p, ac, st);
        @(negedge clk);
        r_dout = io_data_out; r_skip = io_skip; r_sel = io_selected; r_irq = io_interrupt;
        @(posedge clk); #1;
        iot = 1'b0; state = 4'd0;
    endtask

    task automatic do_krb();
        do_iot(c_TTI, 3'd6, 12'o7777, c_F1);
        if (rx_q.size() == 0) check("krb_unexpected", 32'd1, 32'd0);
        else                  check("krb_data", {20'b0, r_dout}, {24'b0, rx_q.pop_front()});
    endtask

    task automatic do_ksf(input logic exp);
        do_iot(c_TTI, 3'd1, 12'o0000, c_F1);
        check("ksf_skip", {31'b0, r_skip}, {31'b0, exp});
    endtask

    task automatic do_tsf(input logic exp);
        do_iot(c_TTO, 3'd1, 12'o0000, c_F1);
        check("tsf_skip", {31'b0, r_skip}, {31'b0, exp});
    endtask

    task automatic tx_put(input logic [7:0] b, input logic tls);
        do_iot(c_TTO, tls ? 3'd6 : 3'd4, {4'b0, b}, c_F1);
        if (tx_q.size() < c_DEPTH) tx_q.push_back(b);
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk);
        check("rx_ready_before_send", {31'b0, rx_ready}, 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_q.push_back(b);
    endtask

    task automatic pop_one_tx();
        @(posedge clk); #1; tx_ready = 1'b1;
        @(posedge clk); #1; tx_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; iot = 1'b0; state = 4'd0; rx_valid = 1'b0; tx_ready = 1'b0;
        rx_q.delete(); tx_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic sample_chk(input string name, input logic act_sel, input logic exp);
        check(name, {31'b0, act_sel}, {31'b0, exp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{c_TTI, 3'd1, c_F1,    12'o1234, 1'b1, 1'b0, 12'o0000, 1'b1};
        vecs[1] = '{c_TTO, 3'd1, c_F1,    12'o7654, 1'b1, 1'b1, 12'o7654, 1'b1};
        vecs[2] = '{6'o05, 3'd1, c_F1,    12'o4321, 1'b0, 1'b0, 12'o4321, 1'b1};
        vecs[3] = '{c_TTI, 3'd1, 4'b0010, 12'o1111, 1'b0, 1'b0, 12'o1111, 1'b1};
        vecs[4] = '{c_TTI, 3'd2, c_F1,    12'o2222, 1'b1, 1'b0, 12'o0000, 1'b1};
        vecs[5] = '{c_TTO, 3'd2, c_F1,    12'o3333, 1'b1, 1'b0, 12'o3333, 1'b1};
        vecs[6] = '{c_TTO, 3'd1, c_F1,    12'o0070, 1'b1, 1'b0, 12'o0070, 1'b0};
        vecs[7] = '{c_TTI, 3'd1, c_F1,    12'o0000, 1'b1, 1'b0, 12'o0000, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample_chk("reset_tx_valid", tx_valid, 1'b0);
        sample_chk("reset_rx_ready", rx_ready, 1'b1);
        sample_chk("reset_irq", io_interrupt, 1'b1);
        sample_chk("reset_overrun", tx_overrun, 1'b0);
        sample_chk("data_avail", io_data_avail, 1'b1);
        @(posedge clk); #1; reset_n = 1'b1;

        // Decode table from the reset state
        for (int i = 0; i < 8; i++) begin
            do_iot(vecs[i].dev, vecs[i].p, vecs[i].ac, vecs[i].st);
            check($sformatf("vec%0d_sel", i),  {31'b0, r_sel},  {31'b0, vecs[i].e_sel});
            check($sformatf("vec%0d_skip", i), {31'b0, r_skip}, {31'b0, vecs[i].e_skip});
            check($sformatf("vec%0d_dout", i), {20'b0, r_dout}, {20'b0, vecs[i].e_dout});
            check($sformatf("vec%0d_irq", i),  {31'b0, r_irq},  {31'b0, vecs[i].e_irq});
        end

        // Reset asserted mid-stream discards everything
        apply_reset();
        tx_put(8'h11, 1'b0);
        tx_put(8'h12, 1'b0);
        rx_send(8'h21);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h55;
        #2 reset_n = 1'b0;
        rx_q.delete(); tx_q.delete();
        @(negedge clk);
        sample_chk("midreset_tx_valid", tx_valid, 1'b0);
        sample_chk("midreset_rx_ready", rx_ready, 1'b1);
        sample_chk("midreset_irq", io_interrupt, 1'b1);
        rx_valid = 1'b0;
        @(posedge clk); #1; reset_n = 1'b1;
        do_ksf(1'b0);

        // RX path: 'A','B','C'
        apply_reset();
        rx_send(8'h41); rx_send(8'h42); rx_send(8'h43);
        do_ksf(1'b1);
        repeat (3) do_krb();
        do_ksf(1'b0);

        // TX fill and overrun
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            tx_put(8'h30 + 8'(i), 1'b1);
            do_tsf(tx_q.size() < c_DEPTH);
            @(negedge clk);
            sample_chk($sformatf("overrun_after_%0d", i), tx_overrun, i == 8);
        end
        @(negedge clk);
        sample_chk("tx_valid_full", tx_valid, 1'b1);
        pop_one_tx();
        do_tsf(1'b1);
        @(posedge clk); #1; tx_ready = 1'b1;
        for (int k = 0; k < 50 && tx_valid; k++) @(negedge clk);
        sample_chk("tx_drained", tx_valid, 1'b0);
        check("tx_queue_empty", tx_q.size(), 32'd0);
        sample_chk("overrun_sticky", tx_overrun, 1'b1);
        tx_ready = 1'b0;

        // RX full with pending byte, and a true simultaneous push/pop
        apply_reset();
        for (int i = 0; i < 8; i++) rx_send(8'h40 + 8'(i));
        @(negedge clk);
        sample_chk("rx_full_ready", rx_ready, 1'b0);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h48;
        drive_iot(c_TTI, 3'd6, 12'o0000, c_F1);
        @(negedge clk);
        check("krb_full_data", {20'b0, io_data_out}, {24'b0, rx_q.pop_front()});
        sample_chk("rx_full_ready_hold", rx_ready, 1'b0);
        @(posedge clk); #1; iot = 1'b0; state = 4'd0;
        @(negedge clk);
        sample_chk("rx_ready_after_pop", rx_ready, 1'b1);
        @(posedge clk); #1; rx_valid = 1'b0; rx_q.push_back(8'h48);
        @(negedge clk);
        sample_chk("rx_refilled", rx_ready, 1'b0);
        do_krb();
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h49;
        drive_iot(c_TTI, 3'd6, 12'o0000, c_F1);
        @(negedge clk);
        check("krb_simul_data", {20'b0, io_data_out}, {24'b0, rx_q.pop_front()});
        rx_q.push_back(8'h49);
        @(posedge clk); #1; rx_valid = 1'b0; iot = 1'b0; state = 4'd0;
        @(negedge clk);
        sample_chk("rx_count7_ready", rx_ready, 1'b1);
        rx_send(8'h4A);
        @(negedge clk);
        sample_chk("rx_count8_ready", rx_ready, 1'b0);
        repeat (8) do_krb();
        do_ksf(1'b0);

        // TCF on the same edge as a TX pop
        apply_reset();
        tx_put(8'h61, 1'b0);
        tx_put(8'h62, 1'b0);
        @(posedge clk); #1;
        drive_iot(c_TTO, 3'd2, 12'o0000, c_F1);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        iot = 1'b0; state = 4'd0; tx_ready = 1'b0;
        do_tsf(1'b0);
        pop_one_tx();
        do_tsf(1'b1);
        check("tcf_queue_empty", tx_q.size(), 32'd0);

`ifdef TT_KIE_EN
        apply_reset();
        do_iot(c_TTO, 3'd2, 12'o0000, c_F1);
        rx_send(8'h5A);
        @(negedge clk);
        sample_chk("kie_irq_before", io_interrupt, 1'b1);
        do_iot(c_TTI, 3'd5, 12'o0000, c_F1);
        check("kie_no_skip", {31'b0, r_skip}, 32'd0);
        @(negedge clk);
        sample_chk("kie_irq_off", io_interrupt, 1'b0);
        do_iot(c_TTO, 3'd5, 12'o0000, c_F1);
        check("tsk_skip", {31'b0, r_skip}, 32'd1);
        do_iot(c_TTI, 3'd5, 12'o0001, c_F1);
        @(negedge clk);
        sample_chk("kie_irq_on", io_interrupt, 1'b1);
        do_krb();
`else
        apply_reset();
        rx_send(8'h5A);
        do_iot(c_TTI, 3'd5, 12'o0000, c_F1);
        check("code5_skip", {31'b0, r_skip}, 32'd1);
        check("code5_data", {20'b0, r_dout}, 32'h05A);
        do_krb();
        do_ksf(1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
